// File: rtl/rr_mux_4x1_if.sv
// Valid/ready bundle between four source channels and the merged output of rr_mux_4x1.
// The mux takes the slave view; whoever drives the channels and sinks the output takes master.
interface rr_mux_4x1_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [3:0]          in_last;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [1:0]          out_sel;
  logic                out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/rr_mux_4x1.sv
// Four-channel round-robin packet merge with a one-beat registered output stage.
// The grant is held from the first beat of a packet until its last beat transfers.
module rr_mux_4x1 #(
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  rr_mux_4x1_if.slave   bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [1:0]        grant;
  logic [1:0]        last_grant;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [1:0]        out_sel_q;

  logic [1:0]        pick;
  logic              found;
  logic [1:0]        cur_g;
  logic              free;
  logic [3:0]        ready;
  logic              xfer;

  // Round-robin search starting just after the most recently completed channel.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.in_valid[last_grant + k[1:0]]) begin
        pick  = last_grant + k[1:0];
        found = 1'b1;
      end
    end
  end

  assign cur_g = (state == LOCK) ? grant : pick;
  assign free  = !out_valid_q || bus.out_ready;

  always_comb begin
    ready = '0;
    if (!rst && free && (state == LOCK || (en && found)))
      ready[cur_g] = 1'b1;
  end

  assign xfer = |(bus.in_valid & ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'd0;
      last_grant  <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[cur_g*DATA_W +: DATA_W];
      out_last_q  <= bus.in_last[cur_g];
      out_sel_q   <= cur_g;
      if (bus.in_last[cur_g]) begin
        state      <= IDLE;
        last_grant <= cur_g;
      end else begin
        state <= LOCK;
        grant <= cur_g;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Directed bench for rr_mux_4x1: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_rr_mux_4x1;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [1:0]        sel;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  rr_mux_4x1_if #(.DATA_W(DATA_W)) bus ();

  rr_mux_4x1 #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [1:0] sel, input logic [DATA_W-1:0] data, input logic last);
    beat_t b;
    b.sel  = sel;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
    bus.in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  // Monitor: a beat is accepted downstream when valid&ready is seen mid-cycle.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got.sel  = bus.out_sel;
        got.data = bus.out_data;
        got.last = bus.out_last;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("beat", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // 1. Reset with every channel requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    tick();
    bus.in_valid = 4'b0000;
    rst = 1'b0;
    tick();

    // 2. Round-robin single beats, first grant ch0.
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
    bus.in_last  = 4'b1111;
    bus.in_valid = 4'b1111;
    expect_beat(2'd0, 8'hA0, 1'b1);
    expect_beat(2'd1, 8'hA1, 1'b1);
    expect_beat(2'd2, 8'hA2, 1'b1);
    expect_beat(2'd3, 8'hA3, 1'b1);
    expect_beat(2'd0, 8'hA0, 1'b1);
    repeat (5) tick();
    bus.in_valid = 4'b0000;
    tick();

    // 3. Packet lock on ch1 while ch2 keeps requesting.
    bus.in_last  = 4'b0100;
    set_data(2, 8'h22);
    set_data(1, 8'h11);
    bus.in_valid = 4'b0110;
    expect_beat(2'd1, 8'h11, 1'b0);
    expect_beat(2'd1, 8'h12, 1'b0);
    expect_beat(2'd1, 8'h13, 1'b1);
    expect_beat(2'd2, 8'h22, 1'b1);
    tick();
    set_data(1, 8'h12);
    tick();
    set_data(1, 8'h13);
    bus.in_last[1] = 1'b1;
    tick();
    bus.in_valid = 4'b0100;
    tick();
    bus.in_valid = 4'b0000;
    tick();

    // 4. Backpressure with 8'h55 held, then no-bubble follow-on beat.
    bus.in_last   = 4'b1111;
    set_data(3, 8'h55);
    set_data(0, 8'h66);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1001;
    expect_beat(2'd3, 8'h55, 1'b1);
    expect_beat(2'd0, 8'h66, 1'b1);
    tick();
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_data", 32'(bus.out_data), 32'h55);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 4'b0000;
    check("bp_no_bubble", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h66});
    tick();

    // 5. en dropped mid-packet on ch3: packet completes, then nothing granted.
    bus.in_last = 4'b0000;
    set_data(3, 8'h31);
    bus.in_valid = 4'b1000;
    expect_beat(2'd3, 8'h31, 1'b0);
    expect_beat(2'd3, 8'h32, 1'b0);
    expect_beat(2'd3, 8'h33, 1'b1);
    tick();
    en = 1'b0;
    set_data(3, 8'h32);
    tick();
    set_data(3, 8'h33);
    bus.in_last = 4'b1111;
    tick();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_off_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    check("en_off_idle", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 4'b0001;
    set_data(0, 8'h40);
    en = 1'b1;
    expect_beat(2'd0, 8'h40, 1'b1);
    @(negedge clk);
    check("en_on_grant_ch0", 32'(bus.in_ready), 32'b0001);
    tick();
    bus.in_valid = 4'b0000;
    tick();

    // 6. Async reset in the middle of a locked packet on ch2.
    bus.out_ready = 1'b0;
    bus.in_last   = 4'b0000;
    set_data(2, 8'h50);
    bus.in_valid  = 4'b0100;
    tick();
    check("pre_rst_held", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_last   = 4'b1111;
    set_data(0, 8'h60);
    set_data(2, 8'h62);
    bus.in_valid  = 4'b0101;
    expect_beat(2'd0, 8'h60, 1'b1);
    @(negedge clk);
    check("post_rst_grant_ch0", 32'(bus.in_ready), 32'b0001);
    tick();
    bus.in_valid = 4'b0000;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
